// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared widths, NOP/HALT encodings and fetch state enum
package fetch_pkg;
    localparam int DEF_PC_W = 6;
    localparam int DEF_INSTR_W = 11;
    localparam logic [DEF_INSTR_W-1:0] NOP = '0;
    localparam logic [DEF_INSTR_W-1:0] DEF_HALT_WORD = 11'h7FF;
    typedef enum logic {FETCH, HALT} state_t;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: control, load port and pipeline outputs of the fetch stage
//   master: drives STALL/BR_*/LOAD_*, receives INSTR_OUT/COUNTER_OUT/VALID_OUT/HALTED
//   slave : the fetch stage
interface instr_fetch_if import fetch_pkg::*; #(
    parameter int PC_W = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W
) ();
    logic STALL;
    logic BR_TAKEN;
    logic [PC_W-1:0] BR_TARGET;
    logic LOAD_EN;
    logic [PC_W-1:0] LOAD_ADDR;
    logic [INSTR_W-1:0] LOAD_DATA;
    logic [INSTR_W-1:0] INSTR_OUT;
    logic [PC_W-1:0] COUNTER_OUT;
    logic VALID_OUT;
    logic HALTED;
    modport master (
        output STALL, BR_TAKEN, BR_TARGET, LOAD_EN, LOAD_ADDR, LOAD_DATA,
        input INSTR_OUT, COUNTER_OUT, VALID_OUT, HALTED
    );
    modport slave (
        input STALL, BR_TAKEN, BR_TARGET, LOAD_EN, LOAD_ADDR, LOAD_DATA,
        output INSTR_OUT, COUNTER_OUT, VALID_OUT, HALTED
    );
endinterface

// File: rtl/instr_mem.sv
// instr_mem: 2**PC_W x INSTR_W memory, sync write port, async read port
module instr_mem #(
  parameter int PC_W = 6,
  parameter int INSTR_W = 11,
  parameter string INIT_FILE = ""
) (
  input  logic clk,
  input  logic we,
  input  logic [PC_W-1:0] waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [PC_W-1:0] raddr,
  output logic [INSTR_W-1:0] rdata
);
  logic [INSTR_W-1:0] mem [2**PC_W];
  initial mem = '{default: '0};
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, FETCH/HALT state machine and first pipeline register
//   CLK, RST (sync, active-high); bus: instr_fetch_if.slave
//   FETCH_HALT_EN: when defined, fetching HALT_WORD parks the stage in HALT
module instr_fetch import fetch_pkg::*; #(
    parameter int PC_W = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter logic [INSTR_W-1:0] HALT_WORD = DEF_HALT_WORD,
    parameter string INIT_FILE = ""
) (
    input logic CLK,
    input logic RST,
    instr_fetch_if.slave bus
);
    logic [PC_W-1:0] pc_q, pc_d, cnt_d;
    logic [INSTR_W-1:0] rd, instr_d;
    logic valid_d, is_halt;
    state_t state_q, state_d;
    instr_mem #(.PC_W(PC_W), .INSTR_W(INSTR_W), .INIT_FILE(INIT_FILE)) u_mem (
        .clk(CLK), .we(bus.LOAD_EN), .waddr(bus.LOAD_ADDR), .wdata(bus.LOAD_DATA),
        .raddr(pc_q), .rdata(rd)
    );
`ifdef FETCH_HALT_EN
    assign is_halt = rd == HALT_WORD;
    assign bus.HALTED = state_q == HALT;
`else
    assign is_halt = 1'b0;
    assign bus.HALTED = 1'b0;
`endif
    always_comb begin
        pc_d = pc_q;
        instr_d = bus.INSTR_OUT;
        cnt_d = bus.COUNTER_OUT;
        valid_d = bus.VALID_OUT;
        state_d = state_q;
        if (bus.BR_TAKEN) begin
            pc_d = bus.BR_TARGET;
            instr_d = INSTR_W'(NOP);
            valid_d = 1'b0;
            state_d = FETCH;
        end else if (!bus.STALL) begin
            if (state_q == HALT) begin
                instr_d = INSTR_W'(NOP);
                valid_d = 1'b0;
            end else begin
                // the HALT word itself is delivered; the PC parks on it
                instr_d = rd;
                cnt_d = pc_q;
                valid_d = 1'b1;
                pc_d = is_halt ? pc_q : pc_q + 1'b1;
                state_d = is_halt ? HALT : FETCH;
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q <= '0;
            bus.INSTR_OUT <= INSTR_W'(NOP);
            bus.COUNTER_OUT <= '0;
            bus.VALID_OUT <= 1'b0;
            state_q <= FETCH;
        end else begin
            pc_q <= pc_d;
            bus.INSTR_OUT <= instr_d;
            bus.COUNTER_OUT <= cnt_d;
            bus.VALID_OUT <= valid_d;
            state_q <= state_d;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch against a behavioural model
module tb_instr_fetch;
    logic clk = 0;
    logic rst;
    always #5 clk = ~clk;
    instr_fetch_if bus ();
    instr_fetch dut (.CLK(clk), .RST(rst), .bus(bus));

    typedef struct {
        logic [10:0] i;
        logic [5:0] c;
        logic v;
        logic h;
    } exp_t;
    exp_t q[$];
    int n_cmp = 0, n_err = 0;

    logic [10:0] m_mem [64];
    int m_pc = 0;
    logic [10:0] m_i = 0;
    int m_c = 0;
    logic m_v = 0, m_h = 0;

    task automatic step(input logic r, s, b, input int t, input logic le, input int la, input logic [10:0] ld);
        exp_t e;
        @(negedge clk);
        rst = r;
        bus.STALL = s;
        bus.BR_TAKEN = b;
        bus.BR_TARGET = 6'(t);
        bus.LOAD_EN = le;
        bus.LOAD_ADDR = 6'(la);
        bus.LOAD_DATA = ld;
        if (r) begin
            m_pc = 0; m_i = 0; m_c = 0; m_v = 0; m_h = 0;
        end else if (b) begin
            m_pc = t; m_i = 0; m_v = 0; m_h = 0;
        end else if (s) begin
        end else if (m_h) begin
            m_i = 0; m_v = 0;
        end else begin
            m_i = m_mem[m_pc]; m_c = m_pc; m_v = 1;
`ifdef FETCH_HALT_EN
            if (m_mem[m_pc] == 11'h7FF) m_h = 1;
            else m_pc = (m_pc + 1) % 64;
`else
            m_pc = (m_pc + 1) % 64;
`endif
        end
        if (le) m_mem[la] = ld;
        e.i = m_i; e.c = 6'(m_c); e.v = m_v; e.h = m_h;
        q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            n_cmp++;
            if (bus.INSTR_OUT !== e.i || bus.COUNTER_OUT !== e.c || bus.VALID_OUT !== e.v || bus.HALTED !== e.h) begin
                n_err++;
                $display("FAIL out @%0t: got instr=%h pc=%0d valid=%b halted=%b, expected instr=%h pc=%0d valid=%b halted=%b",
                         $time, bus.INSTR_OUT, bus.COUNTER_OUT, bus.VALID_OUT, bus.HALTED, e.i, e.c, e.v, e.h);
            end
        end
    end

    initial begin
        logic [10:0] d;
        rst = 1;
        bus.STALL = 0; bus.BR_TAKEN = 0; bus.BR_TARGET = 0;
        bus.LOAD_EN = 0; bus.LOAD_ADDR = 0; bus.LOAD_DATA = 0;
        step(1, 0, 0, 0, 0, 0, 0);
        for (int a = 0; a < 64; a++) begin
            d = a < 3 ? 11'(a + 1) : 11'($urandom_range(0, 2046));
            step(1, 0, 0, 0, 1, a, d);
        end
        run(6);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0, 0, 0);
        run(1);
        step(0, 1, 1, 40, 0, 0, 0);
        run(2);
        step(0, 0, 1, 62, 0, 0, 0);
        run(4);
        step(0, 0, 1, 0, 1, 3, 11'h7FF);
        run(14);
        step(0, 0, 1, 0, 0, 0, 0);
        run(3);
        step(0, 0, 1, 20, 1, 3, 11'h123);
        run(1);
        step(1, 1, 1, 33, 0, 0, 0);
        run(3);
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 11'h2AA);
        step(0, 0, 1, 0, 0, 0, 0);
        run(2);
        for (int k = 0; k < 400; k++) begin
            d = ($urandom_range(0, 15) == 0) ? 11'h7FF : 11'($urandom_range(0, 2046));
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 63), $urandom_range(0, 3) == 0, $urandom_range(0, 63), d);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
